// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage
// ROM window is [ROM_BASE_ADDR, ROM_END_ADDR); fetch_entry_t is one buffered fetch.
package ifetch_pkg;
    localparam logic [31:0] ROM_BASE_ADDR     = 32'h0000_1000;
    localparam logic [31:0] ROM_END_ADDR      = 32'h0000_2000;
    localparam int          IFETCH_FIFO_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush
// Ports: clk, rst_n (async active-low), flush (priority over push/pop), push, pop,
//        din (entry to enqueue), full, empty, head (oldest entry).
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = IFETCH_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage - owns the PC, reads the ROM, buffers {pc, instr, fault}
// Ports: clk, rst_n (async active-low), rom_addr/rom_data (combinational ROM port),
//        redirect_valid/redirect_pc (flush + restart), out_valid/out_ready handshake,
//        out_pc/out_instr/out_fault (FIFO head).
// Optional: define FETCH_FAULT_EN to flag fetches outside the ROM window and replace them with NOP.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = ROM_BASE_ADDR,
    parameter int          FIFO_DEPTH = IFETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);
    logic [31:0]  pc;
    logic         full, empty, push, pop, fault;
    fetch_entry_t din, head;
    assign pop  = !empty && out_ready;
    // A slot freed by this cycle's pop can be refilled on the same edge.
    assign push = !redirect_valid && (!full || pop);
`ifdef FETCH_FAULT_EN
    assign fault = !(pc >= ROM_BASE_ADDR && pc < ROM_END_ADDR);
`else
    assign fault = 1'b0;
`endif
    assign din = '{pc: pc, instr: fault ? NOP_INSTR : rom_data, fault: fault};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc & ~32'h3;
        else if (push) pc <= pc + 32'd4;
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    assign rom_addr  = pc;
    assign out_valid = !empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign out_fault = head.fault;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: scoreboard bench for ifetch - expected stream queued on reset/redirect, checked on each pop
module tb_ifetch;
    import ifetch_pkg::*;
    localparam logic [31:0] RST_PC = ROM_BASE_ADDR;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_addr, rom_data, redirect_pc, out_pc, out_instr;
    logic        redirect_valid, out_valid, out_ready, out_fault;
    int          checks = 0;
    int          failures = 0;
    fetch_entry_t q[$];

    ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        logic [31:0] off;
        off = a - ROM_BASE_ADDR;
        return off == 32'd0 ? 32'h11 : off == 32'd4 ? 32'h22 : off == 32'd8 ? 32'h33 : a ^ 32'hC0DE_0000;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    function automatic fetch_entry_t mk(input logic [31:0] a);
        fetch_entry_t r;
        logic f;
`ifdef FETCH_FAULT_EN
        f = !(a >= ROM_BASE_ADDR && a < ROM_END_ADDR);
`else
        f = 1'b0;
`endif
        r.pc    = a;
        r.instr = f ? NOP_INSTR : rom_fn(a);
        r.fault = f;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] start);
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(mk(start + 32'(4 * i)));
    endtask

    // Drives one cycle's inputs at the negedge, scores any pop, then advances to the next negedge.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_entry_t e;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (out_valid && out_ready) begin
            chk("sb_avail", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc", out_pc, e.pc);
                chk("instr", out_instr, e.instr);
                chk("fault", 32'(out_fault), 32'(e.fault));
            end
        end
        if (rv) load(rpc & ~32'h3);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fault", 32'(out_fault), 32'd0);
        chk("rst_addr", rom_addr, RST_PC);
        rst_n = 1'b1;
        load(RST_PC);
        chk("valid_pre", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b0, '0);
        chk("valid_first", 32'(out_valid), 32'd1);
        repeat (3) cycle(1'b1, 1'b0, '0);
        repeat (5) begin
            cycle(1'b0, 1'b0, '0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pc", out_pc, q[0].pc);
            chk("bp_instr", out_instr, q[0].instr);
        end
        chk("bp_addr", rom_addr, q[2].pc);
        repeat (6) cycle(1'b1, 1'b0, '0);
        repeat (2) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, ROM_BASE_ADDR + 32'h43);
        chk("rd_valid", 32'(out_valid), 32'd0);
        chk("rd_addr", rom_addr, ROM_BASE_ADDR + 32'h40);
        cycle(1'b1, 1'b0, '0);
        chk("rd_valid2", 32'(out_valid), 32'd1);
        chk("rd_pc", out_pc, ROM_BASE_ADDR + 32'h40);
        repeat (3) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (5) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, ROM_END_ADDR - 32'd4);
        repeat (4) cycle(1'b1, 1'b0, '0);
        repeat (20) cycle(1'($urandom_range(0, 1)), 1'b0, '0);
        repeat (3) cycle(1'b0, 1'b0, '0);
        chk("mid_valid_pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_addr", rom_addr, RST_PC);
        chk("mid_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load(RST_PC);
        repeat (5) cycle(1'b1, 1'b0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage directly upstream of rombus: owns the PC, drives the ROM address and captures the returned word.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush buffered entries and restart fetch at a new PC.

Parameters:
- RESET_PC, ROM_BASE_ADDR: PC loaded on reset.
- FIFO_DEPTH, 2: fetch buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rom_addr  out  32  byte address to rombus; always equals the pc register.
- rom_data  in  32  word from rombus; combinational, valid in the same cycle as rom_addr.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored.
- out_valid  out  1  FIFO head holds a valid entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction word of the head entry.
- out_fault  out  1  head entry came from an out-of-range PC (FETCH_FAULT_EN only; otherwise tied 0).

Behaviour:
- Reset (asynchronous assert, synchronous release): pc = RESET_PC; FIFO empty; out_valid = 0; out_pc = 0; out_instr = 0; out_fault = 0.
- pop = out_valid && out_ready.
- push = !redirect_valid && (!full || pop).
- On push:
  - enqueue {pc, rom_data, fault} at the tail.
  - pc <= pc + 4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- On pop: advance the head. Push and pop may occur together, including when the FIFO is full; count is unchanged.
- Full with no pop: pc holds and no enqueue occurs. rom_addr still shows pc; the word is re-read later.
- Redirect:
  - Next edge: FIFO cleared, pc <= {redirect_pc[31:2], 2'b00}, no push.
  - A pop in the same cycle is accepted by the consumer, but the entry is discarded with the flush.
  - out_valid is 0 in the following cycle.
  - First post-redirect entry is valid 2 cycles after the redirect cycle.
- Latency:
  - First entry after reset release is visible at the first rising edge (out_valid = 1 one cycle after rst_n rises).
  - Steady state: one instruction per cycle while out_ready = 1.
- FIFO head outputs are registered; no combinational path from rom_data to out_*.
- Reset asserted mid-stream: all state returns to reset values immediately; in-flight entries are lost.
- Output hold: out_* stable while out_valid && !out_ready, unless a redirect occurs.

Optional Feature:
- FETCH_FAULT_EN defined:
  - fault = !(pc >= ROM_BASE_ADDR && pc < ROM_END_ADDR).
  - Faulting entries push out_instr = 32'h00000013 (NOP) and out_fault = 1.
  - Fetch continues sequentially; decode raises the trap and redirects.
- FETCH_FAULT_EN undefined:
  - No range check; out_fault is constant 0.
  - Out-of-range rom_data (X from rombus) is pushed unchanged.

Decomposition:
- typepkg additions:
  - fetch_entry_t packed struct {pc[31:0], instr[31:0], fault}.
  - IFETCH_FIFO_DEPTH constant.
  - NOP_INSTR = 32'h00000013.
  - Reuse existing ROM_BASE_ADDR/ROM_END_ADDR.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Pointers carry one extra wrap bit.
  - flush has priority over push/pop.

Test Plan:
- Reset release, out_ready = 1, ROM words 0x11, 0x22, 0x33 at ROM_BASE_ADDR+0/4/8 -> out_pc ROM_BASE_ADDR, +4, +8 on consecutive cycles starting 1 cycle after reset release; instr matches.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles.
  - FIFO fills to 2 entries; rom_addr frozen at ROM_BASE_ADDR+8; out_* held.
  - After out_ready = 1: the sequence resumes with no skipped or duplicated PC.
- Redirect to ROM_BASE_ADDR+0x43 while full and popping -> next cycle out_valid = 0, rom_addr = ROM_BASE_ADDR+0x40; the cycle after, out_pc = ROM_BASE_ADDR+0x40.
- Wrap-around: redirect to 0xFFFFFFF8 -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- FETCH_FAULT_EN: redirect to ROM_END_ADDR-4 -> entry fault = 0; next entry pc = ROM_END_ADDR, fault = 1, instr = 0x00000013.
- Reset mid-stream: assert rst_n = 0 asynchronously with 2 entries buffered -> out_valid = 0 immediately (before the next edge), rom_addr = RESET_PC.
